hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the event counters.
REQ-002 SHALL have parameter: REG_ADDR_W, 5, register-file address width.
REQ-003 SHALL have parameter: MEM_TIMEOUT, 255, maximum dmem_busy cycles before timeout is flagged.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: mem_read_ID_EXE  in  1  instruction in ID/EXE is a load.
REQ-007 SHALL have port: regfile_waddr_ID_EXE  in  REG_ADDR_W  destination of the ID/EXE instruction.
REQ-008 SHALL have port: instruction_IF_ID_Rs  in  REG_ADDR_W  Rs of the IF/ID instruction.
REQ-009 SHALL have port: instruction_IF_ID_Rt  in  REG_ADDR_W  Rt of the IF/ID instruction.
REQ-010 SHALL have port: uses_rt_IF_ID  in  1  IF/ID instruction reads Rt.
REQ-011 SHALL have port: branch_taken_EXE_MEM  in  1  branch in EXE/MEM resolved taken.
REQ-012 SHALL have port: jump_ID  in  1  jump decoded in ID.
REQ-013 SHALL have port: dmem_busy  in  1  data memory has not completed its access.
REQ-014 SHALL have ports, each out 1: pc_write, if_id_write, id_exe_write, exe_mem_write, if_id_flush, id_exe_flush, exe_mem_flush, id_exe_bubble, mem_timeout.
REQ-015 SHALL have ports: stall_cycles, flush_events  out  CNT_W  saturating event counters.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, TIMEOUT.
REQ-017 SHALL drive the control outputs combinationally from the current state and the inputs, so that they take effect in the same cycle.
REQ-018 SHALL update state and counters on the clock edge only.
REQ-019 SHALL define load_use as: mem_read_ID_EXE AND waddr_ID_EXE != 0 AND (waddr == Rs OR (uses_rt_IF_ID AND waddr == Rt)).
REQ-020 SHALL apply this priority in RUN: dmem_busy > branch_taken_EXE_MEM > load_use > jump_ID.
REQ-021 SHALL, in RUN with no event, drive all *_write = 1 and all flush and bubble outputs = 0.
REQ-022 SHALL, in RUN when dmem_busy = 1, drive all *_write = 0 and no flush, then enter MEM_WAIT.
REQ-023 SHALL, on branch_taken_EXE_MEM, assert if_id_flush, id_exe_flush and exe_mem_flush for exactly 1 cycle with pc_write = 1, and increment flush_events.
REQ-024 SHALL, on load_use, drive pc_write = 0, if_id_write = 0 and id_exe_bubble = 1 for exactly 1 cycle, and increment stall_cycles.
REQ-025 SHALL NOT re-flag load_use in the following cycle, because the bubble clears mem_read_ID_EXE.
REQ-026 SHALL, on jump_ID, assert if_id_flush only for 1 cycle and increment flush_events.
REQ-027 SHALL, in MEM_WAIT, hold all *_write = 0 and increment stall_cycles each cycle.
REQ-028 SHALL keep an internal wait counter in MEM_WAIT.
REQ-029 SHALL return to RUN in the cycle after dmem_busy deasserts; the release cycle is a RUN cycle evaluated normally.
REQ-030 SHALL, when the wait counter reaches MEM_TIMEOUT with dmem_busy still 1, go to TIMEOUT and set mem_timeout.
REQ-031 SHALL treat mem_timeout as sticky.
REQ-032 SHALL, in TIMEOUT, hold all *_write = 0 until rst.
REQ-033 SHALL saturate both counters at all-ones with no wrap.
REQ-034 SHALL, when branch and load_use coincide, flush only; no stall, no stall_cycles increment.

Reset
REQ-035 SHALL, on rst = 1 at a clock edge, set state to RUN and clear stall_cycles, flush_events, the wait counter and mem_timeout.
REQ-036 SHALL, while rst = 1, drive all *_write = 1 and all flush and bubble outputs = 0.
REQ-037 SHALL let rst in MEM_WAIT or TIMEOUT abort the operation immediately.

Structure
REQ-038 SHALL place the FSM state enumeration and the default MEM_TIMEOUT constant in the shared pipeline package.
REQ-039 SHALL instantiate a sub-module sat_counter (CNT_W, increment enable, synchronous clear) for both event counters.

Verification
REQ-040 SHALL cover: load x5 in ID/EXE, IF/ID Rs = 5 -> 1 cycle pc_write = 0, id_exe_bubble = 1, stall_cycles = 1.
REQ-041 SHALL cover: waddr = 0, Rs = 0, mem_read = 1 -> no stall, all writes 1.
REQ-042 SHALL cover: branch_taken and load_use in the same cycle -> three flushes, pc_write = 1, flush_events = 1, stall_cycles = 0.
REQ-043 SHALL cover: dmem_busy for 4 cycles -> writes 0 for 4 cycles, RUN resumes on cycle 5, stall_cycles = 4.
REQ-044 SHALL cover: dmem_busy held 300 cycles -> mem_timeout = 1 after 255 wait cycles, stays 1 after busy drops, cleared by rst.
REQ-045 SHALL cover: stall_cycles preloaded to 0xFFFE by stimulus, 3 stalls -> 0xFFFF, no wrap.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// ============================================================================
// Module : hazard_unit_pkg
// Brief  : Shared pipeline constants: hazard FSM state encoding and defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_unit_pkg;

  localparam int c_state_w = 2;

  localparam logic [c_state_w-1:0] c_st_run      = 2'd0;
  localparam logic [c_state_w-1:0] c_st_mem_wait = 2'd1;
  localparam logic [c_state_w-1:0] c_st_timeout  = 2'd2;

  localparam int c_mem_timeout_default = 255;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Event counter with synchronous clear that sticks at all-ones.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module : hazard_unit
// Brief  : Pipeline stall/flush control with memory-wait timeout and counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = c_mem_timeout_default
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_ID_EXE,
  input  logic [REG_ADDR_W-1:0] regfile_waddr_ID_EXE,
  input  logic [REG_ADDR_W-1:0] instruction_IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] instruction_IF_ID_Rt,
  input  logic                  uses_rt_IF_ID,
  input  logic                  branch_taken_EXE_MEM,
  input  logic                  jump_ID,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_exe_write,
  output logic                  exe_mem_write,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  exe_mem_flush,
  output logic                  id_exe_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int c_wait_w = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_limit = c_wait_w'(MEM_TIMEOUT);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_nxt;
  logic [c_wait_w-1:0]  r_wait_cnt;
  logic [c_wait_w-1:0]  w_wait_nxt;
  logic                 r_mem_timeout;
  logic                 r_prev_bubble;
  logic                 w_timeout_set;
  logic                 w_load_use;
  logic                 w_stall_inc;
  logic                 w_flush_inc;

  // The bubble inserted last cycle already cleared the load, so never re-flag it.
  assign w_load_use = mem_read_ID_EXE && (|regfile_waddr_ID_EXE) && !r_prev_bubble &&
                      ((regfile_waddr_ID_EXE == instruction_IF_ID_Rs) ||
                       (uses_rt_IF_ID && (regfile_waddr_ID_EXE == instruction_IF_ID_Rt)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_exe_write  = 1'b1;
    exe_mem_write = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    id_exe_bubble = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_timeout_set = 1'b0;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    if (!rst) begin
      case (r_state)
        c_st_timeout: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_write  = 1'b0;
          exe_mem_write = 1'b0;
        end
        default: begin
          // MEM_WAIT with busy released behaves exactly like a RUN cycle.
          if (dmem_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_write  = 1'b0;
            exe_mem_write = 1'b0;
            w_stall_inc   = 1'b1;
            w_wait_nxt    = (r_state == c_st_run) ? c_wait_w'(1) : r_wait_cnt + c_wait_w'(1);
            if (w_wait_nxt >= c_wait_limit) begin
              w_state_nxt   = c_st_timeout;
              w_timeout_set = 1'b1;
            end else begin
              w_state_nxt = c_st_mem_wait;
            end
          end else begin
            w_state_nxt = c_st_run;
            w_wait_nxt  = '0;
            if (branch_taken_EXE_MEM) begin
              if_id_flush   = 1'b1;
              id_exe_flush  = 1'b1;
              exe_mem_flush = 1'b1;
              w_flush_inc   = 1'b1;
            end else if (w_load_use) begin
              pc_write      = 1'b0;
              if_id_write   = 1'b0;
              id_exe_bubble = 1'b1;
              w_stall_inc   = 1'b1;
            end else if (jump_ID) begin
              if_id_flush = 1'b1;
              w_flush_inc = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_st_run;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_prev_bubble <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_prev_bubble <= id_exe_bubble;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (w_stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (w_flush_inc),
    .count (flush_events)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: rule-level model compared every cycle plus
// hand-computed checks of the key scenarios.
`default_nettype none

module tb_hazard_unit;

  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 255;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read_ID_EXE;
  logic [4:0]       regfile_waddr_ID_EXE;
  logic [4:0]       instruction_IF_ID_Rs;
  logic [4:0]       instruction_IF_ID_Rt;
  logic             uses_rt_IF_ID;
  logic             branch_taken_EXE_MEM;
  logic             jump_ID;
  logic             dmem_busy;
  logic             pc_write, if_id_write, id_exe_write, exe_mem_write;
  logic             if_id_flush, id_exe_flush, exe_mem_flush, id_exe_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit #(.CNT_W(CNT_W), .REG_ADDR_W(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_read_ID_EXE      (mem_read_ID_EXE),
    .regfile_waddr_ID_EXE (regfile_waddr_ID_EXE),
    .instruction_IF_ID_Rs (instruction_IF_ID_Rs),
    .instruction_IF_ID_Rt (instruction_IF_ID_Rt),
    .uses_rt_IF_ID        (uses_rt_IF_ID),
    .branch_taken_EXE_MEM (branch_taken_EXE_MEM),
    .jump_ID              (jump_ID),
    .dmem_busy            (dmem_busy),
    .pc_write             (pc_write),
    .if_id_write          (if_id_write),
    .id_exe_write         (id_exe_write),
    .exe_mem_write        (exe_mem_write),
    .if_id_flush          (if_id_flush),
    .id_exe_flush         (id_exe_flush),
    .exe_mem_flush        (exe_mem_flush),
    .id_exe_bubble        (id_exe_bubble),
    .mem_timeout          (mem_timeout),
    .stall_cycles         (stall_cycles),
    .flush_events         (flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: pipeline is either timed out, waiting on memory, or
  // handling the highest-priority event; counters are plain saturating ints.
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int unsigned m_streak = 0;
  bit          m_to = 1'b0;
  bit          m_prev_bub = 1'b0;

  always @(negedge clk) begin : model_cmp
    bit          lu;
    bit          frozen;
    bit [3:0]    e_wr;
    bit [2:0]    e_fl;
    bit          e_bub;
    logic [40:0] exp_v;
    logic [40:0] act_v;
    lu = mem_read_ID_EXE && (regfile_waddr_ID_EXE != 0) && !m_prev_bub &&
         ((regfile_waddr_ID_EXE == instruction_IF_ID_Rs) ||
          (uses_rt_IF_ID && (regfile_waddr_ID_EXE == instruction_IF_ID_Rt)));
    frozen = !rst && (m_to || dmem_busy);
    e_wr  = frozen ? 4'b0000 : 4'b1111;
    e_fl  = 3'b000;
    e_bub = 1'b0;
    if (!rst && !frozen) begin
      if (branch_taken_EXE_MEM) e_fl = 3'b111;
      else if (lu) begin
        e_wr  = 4'b0011;
        e_bub = 1'b1;
      end else if (jump_ID) e_fl = 3'b100;
    end
    exp_v = {e_wr, e_fl, e_bub, m_to, m_stall[15:0], m_flush[15:0]};
    act_v = {pc_write, if_id_write, id_exe_write, exe_mem_write,
             if_id_flush, id_exe_flush, exe_mem_flush, id_exe_bubble,
             mem_timeout, stall_cycles, flush_events};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
    end
    if (rst) begin
      m_stall = 0; m_flush = 0; m_streak = 0; m_to = 1'b0; m_prev_bub = 1'b0;
    end else begin
      if (!m_to && dmem_busy) begin
        if (m_stall < CNT_MAX) m_stall++;
        m_streak++;
        if (m_streak >= MEM_TIMEOUT) m_to = 1'b1;
      end else begin
        m_streak = 0;
        if (!m_to) begin
          if ((e_fl != 3'b000) && m_flush < CNT_MAX) m_flush++;
          if (e_bub && m_stall < CNT_MAX) m_stall++;
        end
      end
      m_prev_bub = e_bub;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read_ID_EXE      = 1'b0;
    regfile_waddr_ID_EXE = '0;
    instruction_IF_ID_Rs = '0;
    instruction_IF_ID_Rt = '0;
    uses_rt_IF_ID        = 1'b0;
    branch_taken_EXE_MEM = 1'b0;
    jump_ID              = 1'b0;
    dmem_busy            = 1'b0;
  endtask

  task automatic load(input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    mem_read_ID_EXE      = 1'b1;
    regfile_waddr_ID_EXE = wa;
    instruction_IF_ID_Rs = rs;
    instruction_IF_ID_Rt = rt;
    uses_rt_IF_ID        = urt;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    branch_taken_EXE_MEM = 1'b1;
    dmem_busy = 1'b1;
    tick();
    mid();
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_exe_mem_write", 32'(exe_mem_write), 32'd1);
    chk("rst_if_id_flush", 32'(if_id_flush), 32'd0);
    tick();
    chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);
    idle();
    rst = 1'b0;

    // load x5, consumer Rs=5; held a second cycle to show no re-flag
    load(5'd5, 5'd5, 5'd0, 1'b0);
    mid();
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_id_exe_write", 32'(id_exe_write), 32'd1);
    chk("lu_bubble", 32'(id_exe_bubble), 32'd1);
    tick();
    chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    mid();
    chk("lu_no_reflag", 32'(id_exe_bubble), 32'd0);
    tick();
    idle();
    tick();

    load(5'd7, 5'd3, 5'd7, 1'b1);
    mid();
    chk("rt_bubble", 32'(id_exe_bubble), 32'd1);
    tick();
    chk("rt_stall_cycles", 32'(stall_cycles), 32'd2);
    idle();
    tick();
    load(5'd7, 5'd3, 5'd7, 1'b0);
    mid();
    chk("rt_unused_pc_write", 32'(pc_write), 32'd1);
    tick();

    load(5'd0, 5'd0, 5'd0, 1'b1);
    mid();
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    chk("x0_bubble", 32'(id_exe_bubble), 32'd0);
    tick();

    idle();
    jump_ID = 1'b1;
    mid();
    chk("jump_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("jump_id_exe_flush", 32'(id_exe_flush), 32'd0);
    tick();
    chk("jump_flush_events", 32'(flush_events), 32'd1);
    idle();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    branch_taken_EXE_MEM = 1'b1;
    load(5'd5, 5'd5, 5'd0, 1'b0);
    mid();
    chk("bl_flushes", 32'({if_id_flush, id_exe_flush, exe_mem_flush}), 32'd7);
    chk("bl_pc_write", 32'(pc_write), 32'd1);
    chk("bl_bubble", 32'(id_exe_bubble), 32'd0);
    tick();
    chk("bl_flush_events", 32'(flush_events), 32'd1);
    chk("bl_stall_cycles", 32'(stall_cycles), 32'd0);
    idle();

    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("busy_writes", 32'({pc_write, if_id_write, id_exe_write, exe_mem_write}), 32'd0);
      tick();
    end
    dmem_busy = 1'b0;
    jump_ID = 1'b1;
    mid();
    chk("release_pc_write", 32'(pc_write), 32'd1);
    chk("release_if_id_flush", 32'(if_id_flush), 32'd1);
    tick();
    chk("busy_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("release_flush_events", 32'(flush_events), 32'd2);
    idle();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_busy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) chk("to_before", 32'(mem_timeout), 32'd0);
      if (i == 255) chk("to_after", 32'(mem_timeout), 32'd1);
    end
    dmem_busy = 1'b0;
    tick();
    tick();
    mid();
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_hold_pc_write", 32'(pc_write), 32'd0);
    chk("to_stall_cycles", 32'(stall_cycles), 32'd255);
    tick();
    rst = 1'b1;
    mid();
    chk("to_rst_pc_write", 32'(pc_write), 32'd1);
    tick();
    rst = 1'b0;
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    tick();

    // preload stall_cycles to 0xFFFE with busy bursts shorter than the timeout
    for (int b = 0; b < 258; b++) begin
      dmem_busy = 1'b1;
      repeat (254) tick();
      dmem_busy = 1'b0;
      tick();
    end
    dmem_busy = 1'b1;
    repeat (2) tick();
    dmem_busy = 1'b0;
    tick();
    chk("pre_stall_cycles", 32'(stall_cycles), 32'h0000FFFE);
    chk("pre_mem_timeout", 32'(mem_timeout), 32'd0);
    for (int k = 0; k < 3; k++) begin
      load(5'd5, 5'd5, 5'd0, 1'b0);
      mid();
      chk("sat_bubble", 32'(id_exe_bubble), 32'd1);
      tick();
      chk("sat_stall_cycles", 32'(stall_cycles), 32'h0000FFFF);
      idle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
